// File: rtl/timer_pkg.sv
// Shared definitions for the APB timer responder: register map, STATUS bit
// positions and the timer state encoding (the encoding is visible to software
// through STATUS[3:2], so the values are fixed).
package timer_pkg;

    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_GOAL    = 2'd1;
    localparam logic [1:0] ADDR_CURR    = 2'd2;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

    localparam int STAT_START    = 0;
    localparam int STAT_STOP     = 1;
    localparam int STAT_STATE_LO = 2;
    localparam int STAT_STATE_HI = 3;

    typedef enum logic [1:0] {
        CTR_IDLE     = 2'd0,
        CTR_RUNNING  = 2'd1,
        CTR_COMPLETE = 2'd2,
        CTR_PAUSED   = 2'd3
    } e_ctr_state;

    // GOAL may only change while the timer is not in the middle of a run.
    function automatic logic goal_writable(input e_ctr_state s);
        return (s == CTR_IDLE) || (s == CTR_COMPLETE);
    endfunction

endpackage

// File: rtl/timer_counter_core.sv
// Timer FSM plus up-counter driven by single-cycle start/stop/clear strobes.
// Latency: START commit -> COMPLETE after goal+1 edges; strobes act on the next edge.
// Backpressure: none; strobes are always accepted (ignored where meaningless).
// Ports: clk, reset (async active-low), start_i/stop_i/clear_complete_i strobes,
//        goal_i target count, state_o current FSM state, curr_o current count.
module timer_counter_core
    import timer_pkg::*;
#(
    parameter int timerbits = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 clear_complete_i,
    input  logic [timerbits-1:0] goal_i,
    output e_ctr_state           state_o,
    output logic [timerbits-1:0] curr_o
);

    e_ctr_state           state_q, state_d;
    logic [timerbits-1:0] curr_q, curr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CTR_IDLE;
            curr_q  <= '0;
        end else begin
            state_q <= state_d;
            curr_q  <= curr_d;
        end
    end

    // Priority: STOP, then START, then read-to-clear, then counting. An
    // effective STOP replaces that cycle's increment; a START issued while
    // already RUNNING changes nothing, so counting carries on.
    always_comb begin
        state_d = state_q;
        curr_d  = curr_q;
        if (stop_i) begin
            if (state_q == CTR_RUNNING) begin
                state_d = CTR_PAUSED;
            end
        end else if (start_i && (state_q != CTR_RUNNING)) begin
            state_d = CTR_RUNNING;
            if (state_q != CTR_PAUSED) begin
                curr_d = '0;
            end
        end else if (clear_complete_i && (state_q == CTR_COMPLETE)) begin
            state_d = CTR_IDLE;
        end else if (state_q == CTR_RUNNING) begin
            // Compare with >= so the count can never run past the goal.
            if (curr_q >= goal_i) begin
                state_d = CTR_COMPLETE;
            end else begin
                curr_d = curr_q + timerbits'(1);
            end
        end
    end

    assign state_o = state_q;
    assign curr_o  = curr_q;

endmodule

// File: rtl/apb_timer_responder.sv
// APB-style responder exposing one timer through STATUS/GOAL/CURR registers.
// Latency: each access phase completes after WAIT_STATES cycles with ready low.
// Backpressure: ready held low for the wait states; dropping sel/enable aborts.
// Ports: clk, reset (async active-low), sel/enable/write/addr/wdata bus inputs,
//        rdata/ready/slverr bus outputs (rdata and slverr are zero unless ready).
module apb_timer_responder
    import timer_pkg::*;
#(
    parameter int timerbits   = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel,
    input  logic                 enable,
    input  logic                 write,
    input  logic [1:0]           addr,
    input  logic [timerbits-1:0] wdata,
    output logic [timerbits-1:0] rdata,
    output logic                 ready,
    output logic                 slverr
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    logic [2:0]           wcnt_q, wcnt_d;
    logic [timerbits-1:0] goal_q, goal_d;
    logic                 access;
    logic                 err;
    logic                 start_stb, stop_stb, clear_stb;
    logic [timerbits-1:0] rd_mux;
    e_ctr_state           state;
    logic [timerbits-1:0] curr;

    assign access = sel & enable;
    // Gated by reset so the bus outputs fall to zero the instant reset asserts,
    // even while sel/enable are still held by the initiator.
    assign ready  = reset & access & (wcnt_q == WS);

    always_comb begin
        wcnt_d = wcnt_q;
        if (!access || ready) begin
            wcnt_d = '0;
        end else begin
            wcnt_d = wcnt_q + 3'd1;
        end
    end

    always_comb begin
        err = 1'b0;
        case (addr)
            ADDR_STATUS: err = 1'b0;
            ADDR_GOAL:   err = write & ~goal_writable(state);
            ADDR_CURR:   err = write;
            default:     err = 1'b1;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_STATUS: rd_mux[STAT_STATE_HI:STAT_STATE_LO] = state;
            ADDR_GOAL:   rd_mux = goal_q;
            ADDR_CURR:   rd_mux = curr;
            default:     rd_mux = '0;
        endcase
    end

    assign slverr = ready & err;
    assign rdata  = (ready && !write) ? rd_mux : '0;

    // All side effects happen only on the completing edge of a transfer.
    assign start_stb = ready & write & (addr == ADDR_STATUS) & wdata[STAT_START];
    assign stop_stb  = ready & write & (addr == ADDR_STATUS) & wdata[STAT_STOP];
    assign clear_stb = ready & ~write & (addr == ADDR_STATUS) & (state == CTR_COMPLETE);

    always_comb begin
        goal_d = goal_q;
        if (ready && write && (addr == ADDR_GOAL) && !err) begin
            goal_d = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_q <= '0;
            goal_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            goal_q <= goal_d;
        end
    end

    timer_counter_core #(
        .timerbits (timerbits)
    ) u_core (
        .clk              (clk),
        .reset            (reset),
        .start_i          (start_stb),
        .stop_i           (stop_stb),
        .clear_complete_i (clear_stb),
        .goal_i           (goal_q),
        .state_o          (state),
        .curr_o           (curr)
    );

endmodule
